// File: rtl/mul_seq.sv
// Sequential WIDTHxWIDTH multiplier (MIPS MULT/MULTU) using radix-2 Booth recoding
// over (WIDTH+1)-bit extended operands, one Booth step per clock, start/busy/done control.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int EW = WIDTH + 1;          // extended operand width
  localparam int AW = WIDTH + 2;          // accumulator width, wide enough for any EW-bit product step
  localparam int CW = $clog2(WIDTH + 2);  // iteration counter width

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [EW-1:0]    m_q, m_d;
  logic [EW-1:0]    q_q, q_d;
  logic             q1_q, q1_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [EW-1:0]      a_ext, b_ext;
  logic [AW-1:0]      m_sx, acc_sum, acc_sh;
  logic [EW-1:0]      q_sh;
  logic [2*WIDTH-1:0] product;

  // Handshake: start is accepted on any edge where busy=0 (IDLE or FINISH);
  // done is a single-cycle pulse that never overlaps busy.
  always_comb begin
    a_ext = {sign & a[WIDTH-1], a};
    b_ext = {sign & b[WIDTH-1], b};
    m_sx  = {m_q[EW-1], m_q};

    case ({q_q[0], q1_q})
      2'b10:   acc_sum = acc_q - m_sx;
      2'b01:   acc_sum = acc_q + m_sx;
      default: acc_sum = acc_q;
    endcase

    // Arithmetic right shift of {acc, q, q_1} by one position
    acc_sh  = {acc_sum[AW-1], acc_sum[AW-1:1]};
    q_sh    = {acc_sum[0], q_q[EW-1:1]};
    product = {acc_sh[WIDTH-2:0], q_sh};

    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (start) begin
          m_d     = a_ext;
          q_d     = b_ext;
          q1_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH)) begin
          hi_d    = product[2*WIDTH-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
          state_d = S_FINISH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_FINISH);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential 32x32 multiplier; the multiply counterpart of the team's sequential divider. Services MIPS MULT/MULTU into the HI/LO pair.
- Uses radix-2 Booth recoding over 33-bit extended operands, one step per clock.
- Control is start/busy, the same as the divider, plus a one-cycle done pulse.
- Sits beside the divider in the EX stage. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH. Iteration count is WIDTH+1.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  32  multiplicand, sampled on the start edge
- b  input  32  multiplier, sampled on the start edge
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled on the start edge
- start  input  1  begin operation; honoured only when busy=0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  32  product bits [63:32]
- lo  output  32  product bits [31:0]

Behaviour:
- Reset (synchronous, active-high), at any clock edge including mid-operation: busy=0, done=0, hi=0, lo=0, iteration count=0. An in-flight operation is discarded; no partial result reaches hi/lo.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 33 iterations.
  - FINISH: done=1 for one cycle, then back to IDLE.
  - done and busy are never high together.
- Launch: when start=1 and busy=0 at edge N:
  - Operands are extended to 33 bits. If sign=1, extend with the sign bit; if sign=0, extend with zero.
  - Load M = ext(a).
  - Load Q = ext(b).
  - Clear the Booth bit q_1=0.
  - Clear the 34-bit accumulator A=0.
  - Set count=0 and busy=1.
- Iteration, at edges N+1 .. N+33, using pair {Q[0], q_1}:
  - Pair 10: A = A - sext34(M).
  - Pair 01: A = A + sext34(M).
  - Pair 00 or 11: no add.
  - Then arithmetic-shift {A, Q, q_1} right by 1, replicating A's MSB.
  - count increments by 1.
- Completion, at edge N+33 (the 33rd iteration):
  - {hi, lo} = low 64 bits of the final {A, Q}, which is the exact 2's-complement product modulo 2^64.
  - busy goes to 0 and done goes to 1.
  - At edge N+34, done returns to 0.
  - Launch-to-result latency is 33 cycles.
- hi/lo hold their value from completion until the next completion or reset. They are never disturbed during RUN.
- start while busy=1 is ignored: no restart, no operand resample, count unaffected.
- start on the same edge that done is asserted (count==32 step): ignored, because busy is still 1 at that edge. The earliest relaunch is the edge where done=1 is visible (FINISH), since busy=0 there.
- Operand inputs a, b and sign may change freely after the launch edge.
- Arithmetic widths:
  - The 34-bit A cannot overflow for any 33-bit signed operands.
  - The counter is 6 bits.
  - No saturation. No overflow flag; HI/LO semantics match MIPS.

Test Plan:
- reset, then a=7, b=3, sign=1, start pulse at edge N -> busy=1 from N through N+32, then done=1 for exactly one cycle after edge N+33; hi=0x00000000, lo=0x00000015.
- a=0xFFFFFFF9 (-7), b=3, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- a=b=0xFFFFFFFF:
  - with sign=0 -> hi=0xFFFFFFFE, lo=0x00000001.
  - with sign=1 -> hi=0x00000000, lo=0x00000001.
- a=b=0x80000000:
  - with sign=1 -> hi=0x40000000, lo=0.
  - with sign=0 -> hi=0x40000000, lo=0.
  - a=0x80000000, b=0x7FFFFFFF, sign=1 -> hi=0xC0000000, lo=0x80000000.
- Launch 5*5. At cycle 10, re-assert start with a=9, b=9, and hold start high to completion. Expected:
  - completion occurs exactly 33 cycles after the first launch with lo=25.
  - a new operation launches on the FINISH cycle, giving lo=81 after 33 more cycles.
- Launch 0x12345678*0x9ABCDEF0 with prior hi/lo=(1,2). Assert reset at iteration 20 -> next edge busy=0, done=0, hi=lo=0. A fresh launch then completes normally with the full 33-cycle latency. Also run a random signed/unsigned sweep of at least 10k operations checked against a 64-bit reference model.
